sb_transfer_sequencer: RTL and testbench



---
 rtl/sb_transfer_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_sb_transfer_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sb_transfer_sequencer.sv
// sb_transfer_sequencer
// Queues register-to-register transfer requests from the decoder (2-entry
// FIFO) and plays each one onto the CPU special bus: one DRIVE cycle where
// the source select settles the bus, then one LOAD cycle where the selected
// destinations are strobed and N/Z can be captured. LOAD may chain straight
// into the next DRIVE, giving one transfer every two cycles.
module sb_transfer_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_src,
  input  logic [3:0] req_dst,
  input  logic       req_nz,
  input  logic       flush,
  input  logic [7:0] SB,
  output logic       X_SB,
  output logic       Y_SB,
  output logic       S_SB,
  output logic       AC_SB,
  output logic       ADD_SB_0_6,
  output logic       ADD_SB_7,
  output logic       SB_X,
  output logic       SB_Y,
  output logic       SB_S,
  output logic       SB_AC,
  output logic       nz_load,
  output logic       flag_n,
  output logic       flag_z,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] src;
    logic [3:0] dst;
    logic       nz;
  } op_t;

  localparam logic [2:0] SRC_X      = 3'd0;
  localparam logic [2:0] SRC_Y      = 3'd1;
  localparam logic [2:0] SRC_S      = 3'd2;
  localparam logic [2:0] SRC_AC     = 3'd3;
  localparam logic [2:0] SRC_ADD    = 3'd4;
  localparam logic [2:0] SRC_ADD_LO = 3'd5;
  localparam logic [2:0] SRC_ADD_HI = 3'd6;

  state_e     state_q, state_d;
  op_t        fifo_q [2];
  op_t        cur_q, cur_d;
  op_t        push_op_s;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_s;
  logic       pop_s;
  logic       active_s;
  logic       load_s;

  // Ready comes only from the registered count: no valid->ready path, and a
  // request in a flush cycle is never written.
  always_comb begin
    req_ready     = (count_q < 2'd2);
    push_s        = req_valid & req_ready & ~flush;
    push_op_s.src = req_src;
    push_op_s.dst = req_dst;
    push_op_s.nz  = req_nz;
  end

  // Sequencer next state; the FIFO head is popped whenever we enter DRIVE.
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush && (count_q != 2'd0)) begin
          pop_s   = 1'b1;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The load itself is already committed; flush only stops chaining.
        if (!flush && (count_q != 2'd0)) begin
          pop_s   = 1'b1;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Current-op capture and FIFO pointer/count bookkeeping.
  always_comb begin
    cur_d    = cur_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_s) begin
      cur_d = fifo_q[rd_ptr_q];
    end else begin
      cur_d = cur_q;
    end
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State, current op and FIFO control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; the slot under the write pointer takes the accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= push_op_s;
    end
  end

  // Bus select, load strobe and flag decode; everything is gated by the
  // registered state so an async reset clears it at once.
  always_comb begin
    active_s   = (state_q == ST_DRIVE) || (state_q == ST_LOAD);
    load_s     = (state_q == ST_LOAD);
    X_SB       = active_s & (cur_q.src == SRC_X);
    Y_SB       = active_s & (cur_q.src == SRC_Y);
    S_SB       = active_s & (cur_q.src == SRC_S);
    AC_SB      = active_s & (cur_q.src == SRC_AC);
    ADD_SB_0_6 = active_s & ((cur_q.src == SRC_ADD) || (cur_q.src == SRC_ADD_LO));
    ADD_SB_7   = active_s & ((cur_q.src == SRC_ADD) || (cur_q.src == SRC_ADD_HI));
    SB_X       = load_s & cur_q.dst[0];
    SB_Y       = load_s & cur_q.dst[1];
    SB_S       = load_s & cur_q.dst[2];
    SB_AC      = load_s & cur_q.dst[3];
    done       = load_s;
    nz_load    = load_s & cur_q.nz;
    flag_n     = nz_load & SB[7];
    flag_z     = nz_load & (SB == 8'h00);
    busy       = (state_q != ST_IDLE) || (count_q != 2'd0);
  end

endmodule

// File: tb/tb_sb_transfer_sequencer.sv
// Bench for sb_transfer_sequencer: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model
// (queue of pending ops plus the op currently on the bus).
module tb_sb_transfer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_src;
  logic [3:0] req_dst;
  logic       req_nz;
  logic       flush;
  logic [7:0] sb_bus;
  logic       X_SB, Y_SB, S_SB, AC_SB, ADD_SB_0_6, ADD_SB_7;
  logic       SB_X, SB_Y, SB_S, SB_AC;
  logic       nz_load, flag_n, flag_z, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] src;
    logic [3:0] dst;
    logic       nz;
  } xfer_t;

  // Reference model: pending queue, op on the bus, and where that op is in
  // its two-cycle life (0 nothing, 1 bus settling, 2 registers loading).
  xfer_t m_q[$];
  xfer_t m_cur;
  int    m_phase;

  sb_transfer_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .req_nz     (req_nz),
    .flush      (flush),
    .SB         (sb_bus),
    .X_SB       (X_SB),
    .Y_SB       (Y_SB),
    .S_SB       (S_SB),
    .AC_SB      (AC_SB),
    .ADD_SB_0_6 (ADD_SB_0_6),
    .ADD_SB_7   (ADD_SB_7),
    .SB_X       (SB_X),
    .SB_Y       (SB_Y),
    .SB_S       (SB_S),
    .SB_AC      (SB_AC),
    .nz_load    (nz_load),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Selects as {X,Y,S,AC,ADD_0_6,ADD_7} for each source code.
  function automatic logic [5:0] sel_of(input logic [2:0] src);
    case (src)
      3'd0:    sel_of = 6'b100000;
      3'd1:    sel_of = 6'b010000;
      3'd2:    sel_of = 6'b001000;
      3'd3:    sel_of = 6'b000100;
      3'd4:    sel_of = 6'b000011;
      3'd5:    sel_of = 6'b000010;
      3'd6:    sel_of = 6'b000001;
      default: sel_of = 6'b000000;
    endcase
  endfunction

  task automatic compare_outputs();
    logic [5:0] exp_sel;
    logic [3:0] exp_ld;
    bit         ld;
    ld      = (m_phase == 2);
    exp_sel = (m_phase != 0) ? sel_of(m_cur.src) : 6'd0;
    exp_ld  = ld ? m_cur.dst : 4'd0;
    check_eq("sel", {2'b00, X_SB, Y_SB, S_SB, AC_SB, ADD_SB_0_6, ADD_SB_7}, {2'b00, exp_sel});
    check_eq("load", {4'h0, SB_AC, SB_S, SB_Y, SB_X}, {4'h0, exp_ld});
    check_eq("done", {7'd0, done}, {7'd0, ld});
    check_eq("nz_load", {7'd0, nz_load}, {7'd0, ld && m_cur.nz});
    check_eq("req_ready", {7'd0, req_ready}, {7'd0, m_q.size() < 2});
    check_eq("busy", {7'd0, busy}, {7'd0, (m_phase != 0) || (m_q.size() != 0)});
    if (ld && m_cur.nz) begin
      check_eq("flags", {6'd0, flag_n, flag_z}, {6'd0, sb_bus[7], sb_bus == 8'h00});
    end
  endtask

  // One clock cycle: drive inputs after the edge, compare mid-cycle, then
  // advance the model across the coming edge.
  task automatic cycle(input bit v, input logic [2:0] s, input logic [3:0] d,
                       input bit n, input bit f, input logic [7:0] sb, output bit acc);
    bit    take;
    xfer_t nop;
    @(posedge clk);
    #2;
    req_valid = v; req_src = s; req_dst = d; req_nz = n; flush = f; sb_bus = sb;
    #3;
    compare_outputs();
    acc  = v && (m_q.size() < 2) && !f;
    take = (m_phase != 1) && (m_q.size() > 0) && !f;
    if (m_phase == 1) begin
      m_phase = f ? 0 : 2;
    end else if (take) begin
      m_cur   = m_q.pop_front();
      m_phase = 1;
    end else begin
      m_phase = 0;
    end
    if (f) begin
      m_q.delete();
    end else if (acc) begin
      nop.src = s; nop.dst = d; nop.nz = n;
      m_q.push_back(nop);
    end
  endtask

  task automatic idle(input int n, input logic [7:0] sb);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd7, 4'd0, 1'b0, 1'b0, sb, acc);
  endtask

  initial begin
    bit         acc;
    int         k;
    logic [2:0] hs [3];
    logic [3:0] hd [3];
    bit         hn [3];

    rst_n = 1'b0; req_valid = 1'b0; req_src = 3'd0; req_dst = 4'd0;
    req_nz = 1'b0; flush = 1'b0; sb_bus = 8'h00;
    m_q.delete(); m_phase = 0; m_cur.src = 3'd7; m_cur.dst = 4'd0; m_cur.nz = 1'b0;
    #7;
    compare_outputs();
    #5 rst_n = 1'b1;

    // Single TAX with a negative bus value.
    cycle(1'b1, 3'd3, 4'b0001, 1'b1, 1'b0, 8'h80, acc);
    idle(5, 8'h80);

    // TXS, TAY, TYA with valid held until each is taken.
    hs[0] = 3'd0; hd[0] = 4'b0100; hn[0] = 1'b0;
    hs[1] = 3'd3; hd[1] = 4'b0010; hn[1] = 1'b1;
    hs[2] = 3'd1; hd[2] = 4'b1000; hn[2] = 1'b1;
    k = 0;
    for (int c = 0; c < 14; c++) begin
      if (k < 3) cycle(1'b1, hs[k], hd[k], hn[k], 1'b0, 8'($urandom), acc);
      else       cycle(1'b0, 3'd7, 4'd0, 1'b0, 1'b0, 8'($urandom), acc);
      if (acc) k++;
    end
    check_eq("held_accepts", 8'(k), 8'd3);

    // ADD full byte into AC with a zero bus.
    cycle(1'b1, 3'd4, 4'b1000, 1'b1, 1'b0, 8'h00, acc);
    idle(5, 8'h00);

    // Flush during DRIVE with one op still queued.
    cycle(1'b1, 3'd0, 4'b0010, 1'b1, 1'b0, 8'h11, acc);
    cycle(1'b1, 3'd1, 4'b0001, 1'b1, 1'b0, 8'h22, acc);
    cycle(1'b0, 3'd7, 4'd0, 1'b0, 1'b1, 8'h33, acc);
    idle(4, 8'h44);

    // Flush during LOAD with a queued op and a same-cycle request.
    cycle(1'b1, 3'd2, 4'b0001, 1'b1, 1'b0, 8'h00, acc);
    cycle(1'b1, 3'd0, 4'b1000, 1'b0, 1'b0, 8'h00, acc);
    cycle(1'b0, 3'd7, 4'd0, 1'b0, 1'b0, 8'h00, acc);
    cycle(1'b1, 3'd6, 4'b0100, 1'b1, 1'b1, 8'h00, acc);
    check_eq("flush_drop", {7'd0, acc}, 8'd0);
    idle(5, 8'h5a);

    // Async reset in the middle of a LOAD cycle.
    cycle(1'b1, 3'd3, 4'b1111, 1'b1, 1'b0, 8'hff, acc);
    idle(3, 8'hff);
    #1 rst_n = 1'b0;
    m_q.delete(); m_phase = 0;
    #1 compare_outputs();
    #1 rst_n = 1'b1;
    #1 compare_outputs();

    // Random traffic with occasional flushes; all source codes and masks.
    for (int c = 0; c < 600; c++) begin
      cycle(($urandom_range(0, 9) < 6), 3'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 29) == 0), 8'($urandom), acc);
    end
    idle(6, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
